// File: rtl/seq_pkg.sv
// +------------------------------------------------------------------+
// | seq_pkg: shared icode, status and sequencer-state definitions     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEMORY  = 4'd4,
    S_WB_E    = 4'd5,
    S_WB_M    = 4'd6,
    S_PC_UPD  = 4'd7,
    S_HALT    = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_icode_class.sv
// +------------------------------------------------------------------+
// | seq_icode_class: icode -> memory/writeback/validity classifier    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module seq_icode_class
  import seq_pkg::*;
(
  input  logic [3:0] icode,
  output logic       uses_mem,
  output logic       writes_e,
  output logic       writes_m,
  output logic       valid
);

  always_comb begin
    uses_mem = 1'b0;
    writes_e = 1'b0;
    writes_m = 1'b0;
    valid    = 1'b1;
    case (icode)
      IHALT, INOP, IJXX: ;
      IRRMOVQ, IIRMOVQ, IOPQ: writes_e = 1'b1;
      IRMMOVQ: uses_mem = 1'b1;
      IMRMOVQ: begin
        uses_mem = 1'b1;
        writes_m = 1'b1;
      end
      ICALL, IRET, IPUSHQ: begin
        uses_mem = 1'b1;
        writes_e = 1'b1;
      end
      IPOPQ: begin
        uses_mem = 1'b1;
        writes_e = 1'b1;
        writes_m = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
// +------------------------------------------------------------------+
// | seq_stage_ctrl: multi-cycle Y86-64 SEQ stage sequencer            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module seq_stage_ctrl
  import seq_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_en,
  output logic             pc_en,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic [1:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, next_state;
  logic [3:0] icode_q;
  logic [1:0] next_stat;
  logic       retire;
  logic       latch_icode;
  logic       uses_mem, writes_e, writes_m, valid;

  seq_icode_class u_class (
    .icode    (icode_q),
    .uses_mem (uses_mem),
    .writes_e (writes_e),
    .writes_m (writes_m),
    .valid    (valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      stat        <= STAT_AOK;
      icode_q     <= 4'h0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      stat  <= next_stat;
      if (latch_icode) icode_q <= icode;
      if (retire) instr_count <= instr_count + CNT_ONE;
    end
  end

  always_comb begin
    next_state  = state;
    next_stat   = stat;
    retire      = 1'b0;
    latch_icode = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          next_state = S_HALT;
          next_stat  = STAT_ADR;
        end else begin
          next_state  = S_DECODE;
          latch_icode = 1'b1;
        end
      end
      S_DECODE: begin
        if (!valid) begin
          next_state = S_HALT;
          next_stat  = STAT_INS;
        end else if (icode_q == IHALT) begin
          // halt counts as retired; faults do not
          next_state = S_HALT;
          next_stat  = STAT_HLT;
          retire     = 1'b1;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (uses_mem)      next_state = S_MEMORY;
        else if (writes_e) next_state = S_WB_E;
        else               next_state = S_PC_UPD;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            next_state = S_HALT;
            next_stat  = STAT_ADR;
          end else if (writes_e) next_state = S_WB_E;
          else if (writes_m)     next_state = S_WB_M;
          else                   next_state = S_PC_UPD;
        end
      end
      // E before M so a popq into rsp leaves the memory value in place
      S_WB_E: next_state = writes_m ? S_WB_M : S_PC_UPD;
      S_WB_M: next_state = S_PC_UPD;
      S_PC_UPD: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    mem_en     = 1'b0;
    pc_en      = 1'b0;
    rf_we      = 1'b0;
    rf_wsel    = 1'b0;
    busy       = 1'b1;
    case (state)
      S_FETCH:   fetch_en   = 1'b1;
      S_DECODE:  decode_en  = 1'b1;
      S_EXECUTE: execute_en = 1'b1;
      S_MEMORY:  mem_en     = 1'b1;
      S_WB_E:    rf_we      = 1'b1;
      S_WB_M: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      S_PC_UPD:  pc_en      = 1'b1;
      default:   busy       = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_stage_ctrl.sv
// +------------------------------------------------------------------+
// | tb_seq_stage_ctrl: scoreboard bench for the SEQ stage sequencer   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seq_stage_ctrl;

  // expected vector layout: {busy, fetch, decode, execute, mem, rf_we, rf_wsel, pc}
  localparam logic [7:0] V_F   = 8'b1100_0000;
  localparam logic [7:0] V_D   = 8'b1010_0000;
  localparam logic [7:0] V_E   = 8'b1001_0000;
  localparam logic [7:0] V_M   = 8'b1000_1000;
  localparam logic [7:0] V_WBE = 8'b1000_0100;
  localparam logic [7:0] V_WBM = 8'b1000_0110;
  localparam logic [7:0] V_P   = 8'b1000_0001;
  localparam logic [7:0] V_H   = 8'b0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        imem_error = 1'b0;
  logic        mem_ready = 1'b1;
  logic        dmem_error = 1'b0;
  logic        fetch_en, decode_en, execute_en, mem_en, pc_en, rf_we, rf_wsel, busy;
  logic [1:0]  stat;
  logic [63:0] instr_count;

  int          errors = 0;
  int          checks = 0;
  int          stall = 0;
  logic [7:0]  exp_q[$];

  seq_stage_ctrl #(.CNT_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .icode       (icode),
    .imem_error  (imem_error),
    .mem_ready   (mem_ready),
    .dmem_error  (dmem_error),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .execute_en  (execute_en),
    .mem_en      (mem_en),
    .pc_en       (pc_en),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .stat        (stat),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {busy, fetch_en, decode_en, execute_en, mem_en, rf_we, rf_wsel, pc_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pop one expected stage per cycle; mem_ready is held low for 'stall' MEMORY cycles
  task automatic drain();
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stage", {56'd0, obs_vec()}, {56'd0, e});
      if (mem_en) begin
        mem_ready = (stall > 0) ? 1'b0 : 1'b1;
        if (stall > 0) stall--;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    imem_error = 1'b0;
    dmem_error = 1'b0;
    mem_ready = 1'b1;
    stall = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic kick(input logic [3:0] ic);
    icode = ic;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push5(input logic [7:0] a, b, c, d, e);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    exp_q.push_back(d); exp_q.push_back(e);
  endtask

  initial begin
    tick();
    do_reset();
    chk("reset_vec", {56'd0, obs_vec()}, 64'd0);
    chk("reset_stat", {62'd0, stat}, 64'd0);
    chk("reset_cnt", instr_count, 64'd0);

    // irmovq
    kick(4'h3);
    push5(V_F, V_D, V_E, V_WBE, V_P);
    drain();
    chk("irmovq_cnt", instr_count, 64'd1);

    // popq with two stall cycles
    icode = 4'hB; stall = 2;
    push5(V_F, V_D, V_E, V_M, V_M);
    exp_q.push_back(V_M); exp_q.push_back(V_WBE); exp_q.push_back(V_WBM); exp_q.push_back(V_P);
    drain();
    chk("popq_cnt", instr_count, 64'd2);

    // nop
    icode = 4'h1;
    exp_q.push_back(V_F); exp_q.push_back(V_D); exp_q.push_back(V_E); exp_q.push_back(V_P);
    drain();
    // rmmovq
    icode = 4'h4;
    push5(V_F, V_D, V_E, V_M, V_P);
    drain();
    // mrmovq
    icode = 4'h5;
    push5(V_F, V_D, V_E, V_M, V_WBM);
    exp_q.push_back(V_P);
    drain();
    // call
    icode = 4'h8;
    push5(V_F, V_D, V_E, V_M, V_WBE);
    exp_q.push_back(V_P);
    drain();
    chk("mix_cnt", instr_count, 64'd6);

    // halt, then ignored start pulses
    icode = 4'h0;
    exp_q.push_back(V_F); exp_q.push_back(V_D); exp_q.push_back(V_H);
    drain();
    chk("halt_stat", {62'd0, stat}, 64'd1);
    chk("halt_cnt", instr_count, 64'd7);
    start = 1'b1;
    exp_q.push_back(V_H);
    drain();
    start = 1'b0;
    exp_q.push_back(V_H); exp_q.push_back(V_H);
    drain();
    chk("halt_sticky_cnt", instr_count, 64'd7);

    // invalid icode
    do_reset();
    kick(4'hC);
    exp_q.push_back(V_F); exp_q.push_back(V_D); exp_q.push_back(V_H);
    drain();
    chk("ins_stat", {62'd0, stat}, 64'd3);
    chk("ins_cnt", instr_count, 64'd0);

    // instruction fetch fault
    do_reset();
    imem_error = 1'b1;
    kick(4'h3);
    exp_q.push_back(V_F);
    drain();
    imem_error = 1'b0;
    exp_q.push_back(V_H); exp_q.push_back(V_H);
    drain();
    chk("imem_stat", {62'd0, stat}, 64'd2);
    chk("imem_cnt", instr_count, 64'd0);

    // data fault on mrmovq
    do_reset();
    dmem_error = 1'b1;
    kick(4'h5);
    push5(V_F, V_D, V_E, V_M, V_H);
    drain();
    dmem_error = 1'b0;
    chk("dmem_stat", {62'd0, stat}, 64'd2);
    chk("dmem_cnt", instr_count, 64'd0);

    // reset during a MEMORY stall
    do_reset();
    kick(4'h1);
    exp_q.push_back(V_F); exp_q.push_back(V_D); exp_q.push_back(V_E); exp_q.push_back(V_P);
    drain();
    chk("pre_rst_cnt", instr_count, 64'd1);
    icode = 4'hB; stall = 50;
    push5(V_F, V_D, V_E, V_M, V_M);
    drain();
    reset = 1'b1;
    tick();
    chk("midrst_vec", {56'd0, obs_vec()}, 64'd0);
    chk("midrst_stat", {62'd0, stat}, 64'd0);
    chk("midrst_cnt", instr_count, 64'd0);
    reset = 1'b0; mem_ready = 1'b1; stall = 0;
    tick();
    chk("idle_stays", {56'd0, obs_vec()}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the Y86-64 SEQ processor. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, and emits one stage-enable per cycle. It serializes the dstE and dstM writebacks onto the single register-file write port, and produces the processor status code. It sits beside the datapath and drives the enables of the fetch logic, `registerfile`, ALU, data memory and PC register.

## Interface
Parameters:
- `CNT_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins execution from IDLE.
- `icode` in 4: instruction code from fetch; valid during FETCH.
- `imem_error` in 1: instruction-memory fault; valid during FETCH.
- `mem_ready` in 1: data-memory access complete; sampled in MEMORY.
- `dmem_error` in 1: data-memory fault; qualified by `mem_ready`.
- `fetch_en`, `decode_en`, `execute_en`, `mem_en`, `pc_en` out 1 each: stage enables.
- `rf_we` out 1: register-file write strobe.
- `rf_wsel` out 1: write-data select; 0 = valE/dstE, 1 = valM/dstM.
- `stat` out 2: status code; 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `busy` out 1: high in every state except IDLE and HALT.
- `instr_count` out `CNT_W`: number of retired instructions.

## Operation
- **States:** IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB_E, WB_M, PC_UPD, HALT.
- **Moore outputs.** Exactly one enable is high per state:
  - FETCH → `fetch_en`; DECODE → `decode_en`; EXECUTE → `execute_en`; MEMORY → `mem_en`; PC_UPD → `pc_en`.
  - WB_E → `rf_we=1`, `rf_wsel=0`.
  - WB_M → `rf_we=1`, `rf_wsel=1`.
  - IDLE and HALT → all enables 0.
- **icode latch.** `icode` is captured into `icode_q` on the FETCH→DECODE edge. All later decisions use `icode_q`.
- **Instruction classes** (from `icode_q`):
  - uses_mem: 4, 5, 8, 9, A, B.
  - writes_e: 2, 3, 6, 8, 9, A, B.
  - writes_m: 5, B.
  - valid: 0..B.
- **Transitions:**
  - IDLE → FETCH on `start`.
  - FETCH → HALT with `stat=ADR` if `imem_error`; otherwise → DECODE.
  - DECODE:
    - → HALT with `stat=INS` if `icode_q` > B.
    - → HALT with `stat=HLT` if `icode_q` = 0; `instr_count` increments.
    - otherwise → EXECUTE.
  - EXECUTE → MEMORY if uses_mem; otherwise → WB_E if writes_e; otherwise → PC_UPD.
  - MEMORY holds while `!mem_ready`. When `mem_ready`:
    - `dmem_error=1` → HALT with `stat=ADR`.
    - otherwise → WB_E if writes_e, else WB_M if writes_m, else PC_UPD.
  - WB_E → WB_M if writes_m, else PC_UPD.
  - WB_M → PC_UPD.
  - PC_UPD → FETCH; `instr_count` increments on this edge.
  - HALT is sticky; only `reset` leaves it.
- **Write gating for cmovXX is not done here.** The cmov write is still strobed. `dstE_logic` already forces dstE = 0xF when `cnd` is false, and the register file ignores writes to 0xF.
- **Faulting instructions do not retire.** ADR and INS leave `instr_count` unchanged.
- **Counter** wraps modulo 2^`CNT_W`.

## Timing
- **Reset values:** state IDLE, all enables 0, `stat=0`, `busy=0`, `instr_count=0`, `icode_q=0`.
- **Reset mid-instruction:** takes effect on the next edge from any state, including MEMORY stalls. No write strobe is issued after the reset edge.
- **Latency** (FETCH entry to next FETCH, `mem_ready` already high):
  - nop: 4 cycles.
  - OPq, irmovq, cmovXX: 5 cycles.
  - rmmovq: 5 cycles.
  - mrmovq, call, ret, pushq: 6 cycles.
  - popq: 7 cycles.
  - Each cycle `mem_ready` is low in MEMORY adds one cycle.
- **Ignored inputs:** `start` outside IDLE; `mem_ready` and `dmem_error` outside MEMORY.
- **No double writes:** `rf_we` is high for exactly one cycle per write.
- **popq write order:** the rsp write (WB_E) always precedes the rA write (WB_M). When rA = rsp, the memory value therefore wins.

## Structure
- **Shared package `seq_pkg`** holds:
  - icode constants (IHALT…IPOPQ);
  - stat constants (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS);
  - the state enum.
- **Sub-module `seq_icode_class`**: combinational decoder from icode to uses_mem, writes_e, writes_m and valid. It is reusable by fetch.

## Test plan
- **irmovq:** `reset`, `start`, icode=3, `mem_ready=1` → states F,D,E,WB_E,P; `rf_we` high one cycle with `rf_wsel=0`; `instr_count`=1.
- **popq with stall:** icode=B, `mem_ready` low for 2 cycles → MEMORY held 3 cycles; then WB_E (`rf_wsel=0`), WB_M (`rf_wsel=1`), P; 9 cycles total.
- **halt:** icode=0 → HALT after DECODE; `stat=1`, `busy=0`, `instr_count`=1; further `start` pulses are ignored.
- **Invalid icode and fetch fault:** icode=C → `stat=3`, `instr_count` unchanged. Separately, `imem_error` in FETCH → `stat=2`, and DECODE is never entered.
- **Data fault:** icode=5 with `mem_ready=1`, `dmem_error=1` → HALT, `stat=2`, no `rf_we` pulse.
- **Reset mid-stall:** `reset` asserted during a MEMORY stall → next cycle IDLE, all outputs at reset values, `instr_count`=0.
